// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_ACK1  = 4'd3,
        ST_WDATA = 4'd4,
        ST_ACK2W = 4'd5,
        ST_RDATA = 4'd6,
        ST_ACK2R = 4'd7,
        ST_STOP  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } qphase_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // SCL is held low in the first and last quarter of every data/ack bit cell.
    function automatic logic scl_low_q(input qphase_t ph);
        return (ph == Q0) || (ph == Q3);
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-bit timebase: CLK_DIV clocks per quarter, 2-bit phase within the bit cell.
module i2c_qtick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_en,
    output logic    o_tick,
    output qphase_t o_phase
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    qphase_t    r_phase;

    // Divider and phase counter; both park at zero whenever the master is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 8'd0;
            r_phase <= Q0;
        end else if (!i_en) begin
            r_cnt   <= 8'd0;
            r_phase <= Q0;
        end else if (r_cnt == LAST) begin
            r_cnt   <= 8'd0;
            r_phase <= qphase_t'(r_phase + 2'd1);
        end else begin
            r_cnt   <= r_cnt + 8'd1;
        end
    end

    assign o_tick  = i_en && (r_cnt == LAST);
    assign o_phase = r_phase;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address, ACK, one data byte, ACK/NACK, STOP.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        scl,
    inout  wire        sda
);

    state_t     r_state;
    state_t     w_state_nxt;
    qphase_t    w_phase;
    logic       w_tick;
    logic       w_cell_end;
    logic       w_sample;
    logic       w_accept;
    logic       w_scl_oe;
    logic       w_sda_oe;
    logic [7:0] r_shift;
    logic [7:0] r_wbyte;
    logic [7:0] r_rx;
    logic [7:0] r_rdata;
    logic [2:0] r_bitcnt;
    logic       r_rw;
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;
    logic       r_scl_oe;
    logic       r_sda_oe;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (r_busy),
        .o_tick  (w_tick),
        .o_phase (w_phase)
    );

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_cell_end = w_tick && (w_phase == Q3);
    assign w_sample   = w_tick && (w_phase == Q2);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every transition except command acceptance happens at a bit-cell boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_START; else w_state_nxt = ST_IDLE;
            ST_START: if (w_cell_end) w_state_nxt = ST_ADDR; else w_state_nxt = ST_START;
            ST_ADDR:  if (w_cell_end && (r_bitcnt == 3'd0)) w_state_nxt = ST_ACK1; else w_state_nxt = ST_ADDR;
            ST_ACK1: begin
                if (!w_cell_end)             w_state_nxt = ST_ACK1;
                else if (r_ack_err)          w_state_nxt = ST_STOP;
                else if (r_rw == RW_WRITE)   w_state_nxt = ST_WDATA;
                else                         w_state_nxt = ST_RDATA;
            end
            ST_WDATA: if (w_cell_end && (r_bitcnt == 3'd0)) w_state_nxt = ST_ACK2W; else w_state_nxt = ST_WDATA;
            ST_ACK2W: if (w_cell_end) w_state_nxt = ST_STOP; else w_state_nxt = ST_ACK2W;
            ST_RDATA: if (w_cell_end && (r_bitcnt == 3'd0)) w_state_nxt = ST_ACK2R; else w_state_nxt = ST_RDATA;
            ST_ACK2R: if (w_cell_end) w_state_nxt = ST_STOP; else w_state_nxt = ST_ACK2R;
            ST_STOP:  if (w_cell_end) w_state_nxt = ST_IDLE; else w_state_nxt = ST_STOP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus drive per state and quarter; '1' means pull the line low.
    always_comb begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_scl_oe = 1'b0;
                w_sda_oe = 1'b0;
            end
            ST_START: begin
                w_scl_oe = (w_phase == Q3);
                w_sda_oe = (w_phase == Q2) || (w_phase == Q3);
            end
            ST_ADDR, ST_WDATA: begin
                w_scl_oe = scl_low_q(w_phase);
                w_sda_oe = ~r_shift[7];
            end
            ST_ACK1, ST_ACK2W, ST_RDATA, ST_ACK2R: begin
                // Slave owns SDA here; for ACK2R leaving it released is the master NACK.
                w_scl_oe = scl_low_q(w_phase);
                w_sda_oe = 1'b0;
            end
            ST_STOP: begin
                w_scl_oe = (w_phase == Q0);
                w_sda_oe = (w_phase == Q0) || (w_phase == Q1);
            end
            default: begin
                w_scl_oe = 1'b0;
                w_sda_oe = 1'b0;
            end
        endcase
    end

    // Registered open-drain enables; reset releases both lines immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_oe <= 1'b0;
            r_sda_oe <= 1'b0;
        end else begin
            r_scl_oe <= w_scl_oe;
            r_sda_oe <= w_sda_oe;
        end
    end

    // Datapath: command capture, bit shifting at cell ends, SDA sampling at Q2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= 8'h00;
            r_wbyte   <= 8'h00;
            r_rx      <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_rw      <= 1'b0;
            r_ack_err <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= {addr, rw};
            r_wbyte   <= wdata;
            r_rx      <= 8'h00;
            r_bitcnt  <= 3'd7;
            r_rw      <= rw;
            r_ack_err <= 1'b0;
        end else if (w_sample) begin
            case (r_state)
                ST_ACK1, ST_ACK2W: if (sda == NACK) r_ack_err <= 1'b1;
                ST_RDATA:          r_rx <= {r_rx[6:0], sda};
                default:           r_rx <= r_rx;
            endcase
        end else if (w_cell_end) begin
            case (r_state)
                ST_ADDR: begin
                    if (r_bitcnt == 3'd0) begin
                        r_shift  <= r_wbyte;
                        r_bitcnt <= 3'd7;
                    end else begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 3'd1;
                    end
                end
                ST_WDATA, ST_RDATA: begin
                    r_shift  <= {r_shift[6:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 3'd1;
                end
                default: r_bitcnt <= r_bitcnt;
            endcase
        end
    end

    // Host handshake: busy from acceptance to the end of STOP, then a one-clock done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if ((r_state == ST_STOP) && w_cell_end) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                if (r_rw == RW_READ) r_rdata <= r_rx;
            end
        end
    end

    assign scl     = r_scl_oe ? 1'b0 : 1'bz;
    assign sda     = r_sda_oe ? 1'b0 : 1'bz;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl with a scripted slave and a bus monitor.
module tb_i2c_master_ctrl;

    localparam int D  = 4;
    localparam int QP = 4 * D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    wire  [7:0] rdata;
    wire        busy;
    wire        done;
    wire        ack_err;
    wire        scl;
    wire        sda;
    logic       slv_drive;
    logic       mon_clr;

    pullup (scl);
    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.CLK_DIV(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        ack_err;
        logic [7:0]  rdata;
        int          flen;
        logic [31:0] fbits;
        int          nper;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_rdata;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor state.
    logic        m_prev_scl = 1'b1;
    logic        m_prev_sda = 1'b1;
    int          m_cnt = 0;
    logic [31:0] m_bits = 32'd0;
    int          m_flen = 0;
    logic [31:0] m_fbits = 32'd0;
    int          m_starts = 0;
    int          m_stops = 0;
    int          m_dones = 0;
    int          m_per_bad = 0;
    int          m_per_n = 0;
    int          m_last_fall = 0;
    logic        m_fall_valid = 1'b0;

    // Decode START/STOP, collect bits on SCL rise, time SCL falling edges.
    always @(negedge clk) begin
        m_prev_scl <= scl;
        m_prev_sda <= sda;
        if (mon_clr) begin
            m_fall_valid <= 1'b0;
        end else begin
            if (m_prev_scl && scl && m_prev_sda && !sda) begin
                m_cnt    <= 0;
                m_bits   <= 32'd0;
                m_starts <= m_starts + 1;
            end else if (m_prev_scl && scl && !m_prev_sda && sda) begin
                m_flen  <= m_cnt;
                m_fbits <= m_bits;
                m_stops <= m_stops + 1;
            end
            if (!m_prev_scl && scl) begin
                m_bits <= {m_bits[30:0], sda};
                m_cnt  <= m_cnt + 1;
            end
            if (m_prev_scl && !scl) begin
                if (m_fall_valid) begin
                    m_per_n <= m_per_n + 1;
                    if ((cyc - m_last_fall) != QP) m_per_bad <= m_per_bad + 1;
                end
                m_fall_valid <= 1'b1;
                m_last_fall  <= cyc;
            end
            if (done) begin
                m_fall_valid <= 1'b0;
                m_dones      <= m_dones + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave scripted by SCL falling-edge index k (k=0 is the START fall).
    task automatic slave_run(input logic s_ack_a, input logic r, input logic [7:0] b, input logic s_ack_d);
        int   last_k;
        bit   found;
        logic prev;
        last_k = s_ack_a ? 18 : 9;
        for (int k = 0; k <= last_k; k++) begin
            found = 1'b0;
            prev  = scl;
            for (int t = 0; t < 400 && !found; t++) begin
                @(negedge clk);
                if (prev && !scl) found = 1'b1;
                prev = scl;
            end
            check_eq("slave_fall", 32'(found), 32'd1);
            if (!found) break;
            repeat (2) @(posedge clk);
            #1;
            if (k == 8)                          slv_drive = s_ack_a;
            else if (k >= 9 && k <= 16 && r)     slv_drive = !b[7 - (k - 9)];
            else if (k == 17 && !r)              slv_drive = s_ack_d;
            else                                 slv_drive = 1'b0;
        end
        slv_drive = 1'b0;
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic s_ack_a, input logic s_ack_d, input logic [7:0] s_byte,
                           input int extra_at);
        exp_t e;
        exp_t g;
        int   n;
        bit   got;
        int   st0, sp0, pb0, pn0, dn0;
        e.lat     = s_ack_a ? (2 + 20 * QP) : (2 + 11 * QP);
        e.ack_err = !s_ack_a || (!r && !s_ack_d);
        if (r && s_ack_a) exp_rdata = s_byte;
        e.rdata = exp_rdata;
        if (!s_ack_a) begin
            e.flen = 10; e.nper = 9;
            e.fbits = {22'd0, a, r, 1'b1, 1'b0};
        end else if (r) begin
            e.flen = 19; e.nper = 18;
            e.fbits = {13'd0, a, 1'b1, 1'b0, s_byte, 1'b1, 1'b0};
        end else begin
            e.flen = 19; e.nper = 18;
            e.fbits = {13'd0, a, 1'b0, 1'b0, wd, !s_ack_d, 1'b0};
        end
        sb_q.push_back(e);
        st0 = m_starts; sp0 = m_stops; pb0 = m_per_bad; pn0 = m_per_n; dn0 = m_dones;
        n = 0; got = 1'b0;
        fork
            begin
                @(negedge clk);
                addr = a; rw = r; wdata = wd; start = 1'b1;
                n = 1;
                for (int t = 0; t < 3000 && !got; t++) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (n == 2) begin
                        start = 1'b0;
                        check_eq("busy_rise", 32'(busy), 32'd1);
                    end
                    if (extra_at != 0 && n == extra_at) begin
                        start = 1'b1; wdata = ~wd; addr = 7'h55;
                    end else if (extra_at != 0 && n == extra_at + 1) begin
                        start = 1'b0;
                    end
                    if (done) got = 1'b1;
                end
                start = 1'b0;
            end
            slave_run(s_ack_a, r, s_byte, s_ack_d);
        join
        check_eq("done_seen", 32'(got), 32'd1);
        g = sb_q.pop_front();
        check_eq("latency", n, g.lat);
        check_eq("ack_err", 32'(ack_err), 32'(g.ack_err));
        check_eq("rdata", 32'(rdata), 32'(g.rdata));
        check_eq("busy_at_done", 32'(busy), 32'd0);
        repeat (QP) @(posedge clk);
        #1;
        check_eq("frame_len", m_flen, g.flen);
        check_eq("frame_bits", m_fbits, g.fbits);
        check_eq("start_cond", m_starts - st0, 32'd1);
        check_eq("stop_cond", m_stops - sp0, 32'd1);
        check_eq("scl_period_bad", m_per_bad - pb0, 32'd0);
        check_eq("scl_period_n", m_per_n - pn0, g.nper);
        check_eq("done_pulses", m_dones - dn0, 32'd1);
        check_eq("ack_err_hold", 32'(ack_err), 32'(g.ack_err));
        check_eq("rdata_hold", 32'(rdata), 32'(g.rdata));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; addr = 7'h00; rw = 1'b0; wdata = 8'h00;
        slv_drive = 1'b0; mon_clr = 1'b0; exp_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_ack_err", 32'(ack_err), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'h00);
        check_eq("rst_scl", 32'(scl), 32'd1);
        check_eq("rst_sda", 32'(sda), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        run_txn(7'b1100110, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 0);
        run_txn(7'h12,      1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 0);
        run_txn(7'b1100110, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 0);
        run_txn(7'b1100110, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 200);

        // Reset in the middle of the address byte, on a low data bit with SCL low.
        @(negedge clk);
        addr = 7'b1100110; rw = 1'b0; wdata = 8'hA5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #2;
        check_eq("pre_rst_scl", 32'(scl), 32'd0);
        check_eq("pre_rst_sda", 32'(sda), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_scl", 32'(scl), 32'd1);
        check_eq("mid_rst_sda", 32'(sda), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_rst_rdata", 32'(rdata), 32'h00);
        exp_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_clr = 1'b1;
        @(posedge clk);
        #1;
        mon_clr = 1'b0;
        repeat (4) @(posedge clk);

        run_txn(7'b1100110, 1'b0, 8'h96, 1'b1, 1'b0, 8'h00, 0);
        run_txn(7'b1100110, 1'b1, 8'h00, 1'b1, 1'b1, 8'hE1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
